// File: rtl/uop_control_fsm_if.sv
// Handshake and control bundle between the accumulator-machine sequencer
// and its datapath/memory environment.
interface uop_control_fsm_if #(
    parameter int unsigned CNTW = 16
);
    logic            start;
    logic [15:0]     ir;
    logic            acc_zero;
    logic            mem_ready;
    logic            addr_sel;
    logic            mem_rd;
    logic            mem_wr;
    logic            ir_load;
    logic            pc_inc;
    logic            pc_load;
    logic            acc_load;
    logic [2:0]      alu_op;
    logic            halted;
    logic [1:0]      err;
    logic [CNTW-1:0] retired;

    modport master (
        input  start, ir, acc_zero, mem_ready,
        output addr_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
               acc_load, alu_op, halted, err, retired
    );

    modport slave (
        output start, ir, acc_zero, mem_ready,
        input  addr_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
               acc_load, alu_op, halted, err, retired
    );
endinterface

// File: rtl/uop_control_fsm.sv
// Multicycle fetch/decode/execute sequencer for the unioperand accumulator
// processor, with memory-wait timeout and a retired-instruction counter.
module uop_control_fsm #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNTW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    uop_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPRD,
        S_STORE,
        S_HALT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t          state_q, state_d;
    logic [7:0]      wait_q, wait_d;
    logic [CNTW-1:0] retired_q, retired_d;
    logic [1:0]      err_q, err_d;
    logic [3:0]      opcode;
    logic            timeout;

    assign opcode      = bus.ir[15:12];
    // Last tolerated stall cycle: a further miss now would reach WAIT_MAX.
    assign timeout     = !bus.mem_ready && (wait_q == WAIT_LAST);
    assign bus.retired = retired_q;
    assign bus.err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        retired_d    = retired_q;
        err_d        = err_q;
        bus.addr_sel = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.acc_load = 1'b0;
        bus.alu_op   = 3'b000;
        bus.halted   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_load = 1'b1;
                    bus.pc_inc  = 1'b1;
                    state_d     = S_DECODE;
                end else if (timeout) begin
                    err_d   = 2'b10;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                unique case (opcode)
                    4'h1, 4'h3, 4'h4, 4'h5, 4'h6: state_d = S_OPRD;
                    4'h2: state_d = S_STORE;
                    4'h0: begin
                        retired_d = retired_q + CNTW'(1);
                        state_d   = S_FETCH;
                    end
                    4'h7, 4'h8: begin
                        bus.pc_load = (opcode == 4'h7) ? 1'b1 : bus.acc_zero;
                        retired_d   = retired_q + CNTW'(1);
                        state_d     = S_FETCH;
                    end
                    4'hF: begin
                        retired_d = retired_q + CNTW'(1);
                        state_d   = S_HALT;
                    end
                    default: begin
                        err_d   = 2'b01;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_OPRD: begin
                bus.addr_sel = 1'b1;
                bus.mem_rd   = 1'b1;
                unique case (opcode)
                    4'h3:    bus.alu_op = 3'b001;
                    4'h4:    bus.alu_op = 3'b010;
                    4'h5:    bus.alu_op = 3'b011;
                    4'h6:    bus.alu_op = 3'b100;
                    default: bus.alu_op = 3'b000;
                endcase
                if (bus.mem_ready) begin
                    bus.acc_load = 1'b1;
                    retired_d    = retired_q + CNTW'(1);
                    state_d      = S_FETCH;
                end else if (timeout) begin
                    err_d   = 2'b10;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_STORE: begin
                bus.addr_sel = 1'b1;
                bus.mem_wr   = 1'b1;
                if (bus.mem_ready) begin
                    retired_d = retired_q + CNTW'(1);
                    state_d   = S_FETCH;
                end else if (timeout) begin
                    err_d   = 2'b10;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
